neuron_lif: RTL

Parametrised leaky integrate-and-fire neuron tile, the next generation of the fabric's 3-dendrite neuron. It generalises dendrite count, weight width and membrane width. It adds signed (inhibitory) weights, a configurable firing threshold and a refractory period, and single-edge decay. Tiles are daisy-chained through a serial configuration shift path and instantiated in a 2-D array by the brain top level.

---
 rtl/neuro_pkg.sv | 53 +++++
 rtl/neuron_lif_if.sv | 33 +++
 rtl/neuron_cfg_chain.sv | 55 +++++
 rtl/neuron_lif.sv | 129 ++++++++++++
 4 files changed

// File: rtl/neuro_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : neuro_pkg                                               |
// | Brief  : Shared constants, config-field offsets, clamp helper.   |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
package neuro_pkg;

    localparam int DEF_N_DEND  = 3;
    localparam int DEF_W_W     = 4;
    localparam int DEF_W_U     = 6;
    localparam int DEF_N_DECAY = 8;
    localparam int DEF_W_R     = 3;
    localparam int CLAMP_W     = 32;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_REFRACT = 2'd1,
        ST_CONFIG  = 2'd2
    } lif_state_e;

    function automatic int cfg_w(input int n_dend, input int w_w, input int n_decay,
                                 input int w_u, input int w_r);
        return n_dend * w_w + $clog2(n_decay) + w_u + w_r;
    endfunction

    // Field layout, LSB upward: w[0] .. w[N_DEND-1], tsel, thr, refr
    function automatic int tsel_lsb(input int n_dend, input int w_w);
        return n_dend * w_w;
    endfunction

    function automatic int thr_lsb(input int n_dend, input int w_w, input int n_decay);
        return n_dend * w_w + $clog2(n_decay);
    endfunction

    function automatic int refr_lsb(input int n_dend, input int w_w, input int n_decay,
                                    input int w_u);
        return n_dend * w_w + $clog2(n_decay) + w_u;
    endfunction

    function automatic logic [CLAMP_W-1:0] clamp_u(input logic signed [CLAMP_W-1:0] s,
                                                   input int w_u);
        logic signed [CLAMP_W-1:0] hi;
        hi = (32'sd1 <<< w_u) - 32'sd1;
        if (s < 0)
            return '0;
        else if (s > hi)
            return hi;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/neuron_lif_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : neuron_lif_if                                           |
// | Brief  : Tile-facing bundle: config shift path, spikes, decay.   |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
interface neuron_lif_if
    import neuro_pkg::*;
#(
    parameter int N_DEND  = DEF_N_DEND,
    parameter int N_DECAY = DEF_N_DECAY,
    parameter int W_U     = DEF_W_U
);
    logic              conf_en;
    logic              bs_in;
    logic              bs_out;
    logic              nn_reset;
    logic [N_DEND-1:0] dend;
    logic [N_DECAY-1:0] dbus;
    logic              axon;
    logic [W_U-1:0]    u_out;

    modport master (
        output conf_en, bs_in, nn_reset, dend, dbus,
        input  bs_out, axon, u_out
    );

    modport slave (
        input  conf_en, bs_in, nn_reset, dend, dbus,
        output bs_out, axon, u_out
    );
endinterface
`default_nettype wire

// File: rtl/neuron_cfg_chain.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : neuron_cfg_chain                                        |
// | Brief  : Serial config shift register with decoded field slices. |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module neuron_cfg_chain
    import neuro_pkg::*;
#(
    parameter int N_DEND  = DEF_N_DEND,
    parameter int W_W     = DEF_W_W,
    parameter int W_U     = DEF_W_U,
    parameter int N_DECAY = DEF_N_DECAY,
    parameter int W_R     = DEF_W_R
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    input  wire logic                     shift_en,
    input  wire logic                     bs_in,
    output logic                          bs_out,
    output logic [N_DEND*W_W-1:0]         w_flat,
    output logic [$clog2(N_DECAY)-1:0]    tsel,
    output logic [W_U-1:0]                thr,
    output logic [W_R-1:0]                refr
);
    localparam int SEL_W    = $clog2(N_DECAY);
    localparam int CFG_W    = cfg_w(N_DEND, W_W, N_DECAY, W_U, W_R);
    localparam int TSEL_LSB = tsel_lsb(N_DEND, W_W);
    localparam int THR_LSB  = thr_lsb(N_DEND, W_W, N_DECAY);
    localparam int REFR_LSB = refr_lsb(N_DEND, W_W, N_DECAY, W_U);

    logic [CFG_W-1:0] cfg_q;
    logic [CFG_W-1:0] cfg_d;

    always_comb begin
        cfg_d = cfg_q;
        if (shift_en)
            cfg_d = {cfg_q[CFG_W-2:0], bs_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cfg_q <= '0;
        else
            cfg_q <= cfg_d;
    end

    assign bs_out = cfg_q[CFG_W-1];
    assign w_flat = cfg_q[0 +: N_DEND*W_W];
    assign tsel   = cfg_q[TSEL_LSB +: SEL_W];
    assign thr    = cfg_q[THR_LSB +: W_U];
    assign refr   = cfg_q[REFR_LSB +: W_R];

endmodule
`default_nettype wire

// File: rtl/neuron_lif.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : neuron_lif                                              |
// | Brief  : Leaky integrate-and-fire tile, signed weights, refract. |
// | Rev    : 1.0  initial release                                    |
// +------------------------------------------------------------------+
module neuron_lif
    import neuro_pkg::*;
#(
    parameter int N_DEND  = DEF_N_DEND,
    parameter int W_W     = DEF_W_W,
    parameter int W_U     = DEF_W_U,
    parameter int N_DECAY = DEF_N_DECAY,
    parameter int W_R     = DEF_W_R
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    neuron_lif_if.slave io
);
    localparam int SEL_W = $clog2(N_DECAY);
    localparam int SUM_W = W_U + W_W + $clog2(N_DEND) + 1;

    logic [N_DEND*W_W-1:0]  w_flat;
    logic [SEL_W-1:0]       tsel;
    logic [W_U-1:0]         thr;
    logic [W_R-1:0]         refr;

    logic [W_U-1:0]         u_q, u_d;
    logic [W_R-1:0]         rc_q, rc_d;
    logic                   axon_q, axon_d;

    logic signed [SUM_W-1:0] sum;
    logic [W_U-1:0]          v_int;
    logic [W_U-1:0]          v_dec;
    logic [(1<<SEL_W)-1:0]   dbus_ext;
    logic                    fire;
    lif_state_e              state;

    neuron_cfg_chain #(
        .N_DEND  (N_DEND),
        .W_W     (W_W),
        .W_U     (W_U),
        .N_DECAY (N_DECAY),
        .W_R     (W_R)
    ) u_cfg_chain (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (io.conf_en),
        .bs_in    (io.bs_in),
        .bs_out   (io.bs_out),
        .w_flat   (w_flat),
        .tsel     (tsel),
        .thr      (thr),
        .refr     (refr)
    );

    // Pad the decay bus so an out-of-range tsel reads a constant 0 line
    always_comb begin
        dbus_ext                = '0;
        dbus_ext[N_DECAY-1:0]   = io.dbus;
    end

    always_comb begin
        sum = SUM_W'($signed({1'b0, u_q}));
        for (int i = 0; i < N_DEND; i++) begin
            if (io.dend[i])
                sum = sum + SUM_W'($signed(w_flat[i*W_W +: W_W]));
        end
        v_int = W_U'(clamp_u(CLAMP_W'(sum), W_U));
        v_dec = dbus_ext[tsel] ? (v_int >> 1) : v_int;
        fire  = (thr != '0) && (v_dec >= thr);
    end

    always_comb begin
        if (io.conf_en)
            state = ST_CONFIG;
        else if (rc_q != '0)
            state = ST_REFRACT;
        else
            state = ST_RUN;
    end

    always_comb begin
        u_d    = u_q;
        rc_d   = rc_q;
        axon_d = 1'b0;
        if (io.nn_reset) begin
            u_d  = '0;
            rc_d = '0;
        end else begin
            case (state)
                ST_CONFIG: begin
                    u_d  = u_q;
                    rc_d = rc_q;
                end
                ST_REFRACT: begin
                    u_d  = '0;
                    rc_d = rc_q - W_R'(1);
                end
                default: begin
                    if (fire) begin
                        u_d    = '0;
                        rc_d   = refr;
                        axon_d = 1'b1;
                    end else begin
                        u_d    = v_dec;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            u_q    <= '0;
            rc_q   <= '0;
            axon_q <= 1'b0;
        end else begin
            u_q    <= u_d;
            rc_q   <= rc_d;
            axon_q <= axon_d;
        end
    end

    assign io.u_out = u_q;
    assign io.axon  = axon_q;

endmodule
`default_nettype wire
